// File: rtl/ex_alu_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU control codes and execute-unit state encoding.
//                The same code constants are meant to be used by the
//                ALUcontrol decoder so both ends agree on the encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // 4-bit ALUcontrol codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Execute-unit FSM encoding
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ex_alu_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_alu_unit_if
//  Description : Operand/result handshake bundle between the pipeline
//                (master) and the EX-stage execute unit (slave).
//  Signals     : in_valid/in_ready + alu_ctrl/a_i/b_i/shamt_i  (request)
//                out_valid/out_ready + result_o/zero_o/ovf_o   (response)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ex_alu_unit_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [SHW-1:0]   shamt_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             ovf_o;

  modport master (
    output in_valid, alu_ctrl, a_i, b_i, shamt_i, out_ready,
    input  in_ready, out_valid, result_o, zero_o, ovf_o
  );

  modport slave (
    input  in_valid, alu_ctrl, a_i, b_i, shamt_i, out_ready,
    output in_ready, out_valid, result_o, zero_o, ovf_o
  );
endinterface
`default_nettype wire

// File: rtl/ex_alu_unit_alu_comb.sv
`default_nettype none
// ============================================================================
//  Module      : alu_comb
//  Description : Purely combinational AND/OR/ADD/SUB/SLT datapath.
//                SLL and unknown codes give 0 here; the shifter lives in
//                the execute unit.
//  Ports       : alu_ctrl_i  4-bit ALU code
//                a_i, b_i    operands
//                result_o    combinational result
//                ovf_o       signed ADD/SUB overflow (EX_ALU_OVF_EN only)
//  Config      : EX_ALU_OVF_EN adds the overflow output.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       alu_ctrl_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o
`ifdef EX_ALU_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_lt;

  assign w_sum  = a_i + b_i;
  assign w_diff = a_i - b_i;
  assign w_lt   = $signed(a_i) < $signed(b_i);

  always_comb begin
    result_o = '0;
    case (alu_ctrl_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_ADD: result_o = w_sum;
      ALU_SUB: result_o = w_diff;
      ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, w_lt};
      default: result_o = '0;
    endcase
  end

`ifdef EX_ALU_OVF_EN
  // Overflow: ADD when equal-sign operands yield a different-sign sum;
  // SUB when opposite-sign operands yield a result whose sign differs from A.
  always_comb begin
    ovf_o = 1'b0;
    if (alu_ctrl_i == ALU_ADD) begin
      ovf_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (w_sum[WIDTH-1] != a_i[WIDTH-1]);
    end else if (alu_ctrl_i == ALU_SUB) begin
      ovf_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (w_diff[WIDTH-1] != a_i[WIDTH-1]);
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/ex_alu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ex_alu_unit
//  Description : EX-stage execute unit. Takes an ALU code plus operands over
//                a valid/ready handshake and returns a registered result.
//                Logic/arith ops take one cycle; SLL shifts one bit per cycle
//                while stall_o holds the front of the pipeline.
//  Ports       : clk, rst_n (async, active low), flush_i (sync flush)
//                stall_o  high while a shift is in progress
//                bus      ex_alu_unit_if.slave (request/response handshake)
//  Config      : EX_ALU_OVF_EN - register signed ADD/SUB overflow on ovf_o;
//                otherwise ovf_o is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  output logic         stall_o,
  ex_alu_unit_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_sll_multi;
  logic             w_last_shift;
  logic [WIDTH-1:0] w_alu_res;

`ifdef EX_ALU_OVF_EN
  logic             ovf_q, ovf_d;
  logic             w_alu_ovf;
`endif

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_alu_comb (
    .alu_ctrl_i (bus.alu_ctrl),
    .a_i        (bus.a_i),
    .b_i        (bus.b_i),
    .result_o   (w_alu_res)
`ifdef EX_ALU_OVF_EN
    ,
    .ovf_o      (w_alu_ovf)
`endif
  );

  // A flush cycle never accepts, even though in_ready may read high.
  assign w_accept     = bus.in_valid && w_in_ready && !flush_i;
  assign w_sll_multi  = (bus.alu_ctrl == ALU_SLL) && (bus.shamt_i != '0);
  assign w_last_shift = (cnt_q == SHW'(1));

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------- next-state comb
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (w_accept && w_sll_multi) state_d = ST_SHIFT;
        ST_SHIFT: if (w_last_shift)            state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------- output comb
  always_comb begin
    stall_o    = (state_q == ST_SHIFT);
    w_in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  end

  // -------------------------------------------------------- datapath next-state
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
`ifdef EX_ALU_OVF_EN
    ovf_d       = ovf_q;
`endif

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (w_accept) begin
        if (w_sll_multi) begin
          acc_d = bus.a_i;
          cnt_d = bus.shamt_i;
        end else begin
          // SLL by zero passes A straight through in one cycle.
          result_d    = (bus.alu_ctrl == ALU_SLL) ? bus.a_i : w_alu_res;
          out_valid_d = 1'b1;
`ifdef EX_ALU_OVF_EN
          ovf_d       = w_alu_ovf;
`endif
        end
      end
    end else begin
      acc_d = acc_q << 1;
      cnt_d = cnt_q - SHW'(1);
      // Final step publishes the fully shifted value; intermediate acc is
      // never visible on result_o.
      if (w_last_shift) begin
        result_d    = acc_q << 1;
        out_valid_d = 1'b1;
`ifdef EX_ALU_OVF_EN
        ovf_d       = 1'b0;
`endif
      end
    end

    zero_d = (result_d == '0);
  end

  // ------------------------------------------------------------ datapath regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef EX_ALU_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
  assign bus.ovf_o = ovf_q;
`else
  assign bus.ovf_o = 1'b0;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result_o  = result_q;
  assign bus.zero_o    = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_alu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_alu_unit
//  Description : Self-checking bench for ex_alu_unit. Issued operations push
//                their expected response (from a behavioural model) into a
//                queue; a monitor pops and compares on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_alu_unit;

  localparam int W = 32;
  localparam int S = 5;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush_i;
  logic stall_o;

  ex_alu_unit_if #(.WIDTH(W), .SHW(S)) bus ();

  ex_alu_unit #(.WIDTH(W), .SHW(S)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .bus     (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   rand_ready = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Behavioural reference: result straight from the operation definitions.
  function automatic exp_t model(input logic [3:0] code, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [S-1:0] sh);
    exp_t   e;
    longint sa, sb, wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.ovf = 1'b0;
    case (code)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: begin
        wide  = sa + sb;
        e.res = W'(a + b);
`ifdef EX_ALU_OVF_EN
        e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
`endif
      end
      4'b0110: begin
        wide  = sa - sb;
        e.res = W'(a - b);
`ifdef EX_ALU_OVF_EN
        e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
`endif
      end
      4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'b0011: e.res = W'(a << sh);
      default: e.res = '0;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Offer one op; returns 1 ns after the accepting edge.
  task automatic issue(input logic [3:0] code, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [S-1:0] sh, input bit push);
    int guard = 0;
    @(negedge clk);
    bus.alu_ctrl = code;
    bus.a_i      = a;
    bus.b_i      = b;
    bus.shamt_i  = sh;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("accept_timeout", 64'd0, 64'd1);
    if (push) exp_q.push_back(model(code, a, b, sh));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Output-side ready driver: changes only shortly after a rising edge.
  always @(posedge clk) begin
    #2;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'(bus.result_o), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        chk("result", 64'(bus.result_o), 64'(e.res));
        chk("zero",   64'(bus.zero_o),   64'(e.zero));
        chk("ovf",    64'(bus.ovf_o),    64'(e.ovf));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got 0x0 expected 0x1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit rdy_bad;
    logic [3:0] codes [8];
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0011, 4'b1111, 4'b0101};

    rst_n        = 1'b0;
    flush_i      = 1'b0;
    bus.in_valid = 1'b0;
    bus.alu_ctrl = '0;
    bus.a_i      = '0;
    bus.b_i      = '0;
    bus.shamt_i  = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result",    64'(bus.result_o),  64'd0);
    chk("rst_zero",      64'(bus.zero_o),    64'd1);
    chk("rst_stall",     64'(stall_o),       64'd0);
    chk("rst_ovf",       64'(bus.ovf_o),     64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle ops, latency 1
    issue(4'b0010, 32'd7, 32'd5, 5'd0, 1'b1);
    chk("add_latency", 64'(bus.out_valid), 64'd1);
    issue(4'b0110, 32'd9, 32'd9, 5'd0, 1'b1);
    issue(4'b0111, 32'hFFFF_FFFD, 32'd2, 5'd0, 1'b1);

    // SLL 1<<4: four stall cycles with in_ready low
    issue(4'b0011, 32'd1, 32'd0, 5'd4, 1'b1);
    n = 0;
    rdy_bad = 1'b0;
    while (stall_o && n < 100) begin
      if (bus.in_ready) rdy_bad = 1'b1;
      n++;
      @(posedge clk);
      #1;
    end
    chk("sll_stall_cycles", 64'(n), 64'd4);
    chk("sll_in_ready_low", 64'(rdy_bad), 64'd0);
    chk("sll_done_valid", 64'(bus.out_valid), 64'd1);

    issue(4'b0011, 32'd5, 32'd0, 5'd0, 1'b1);
    chk("sll0_latency", 64'(bus.out_valid), 64'd1);

    // Backpressure hold, then pop + accept in the same cycle
    @(posedge clk);
    #2;
    bus.out_ready = 1'b0;
    issue(4'b0010, 32'd1, 32'd1, 5'd0, 1'b1);
    repeat (3) @(negedge clk);
    chk("hold_valid",    64'(bus.out_valid), 64'd1);
    chk("hold_result",   64'(bus.result_o),  64'd2);
    chk("hold_in_ready", 64'(bus.in_ready),  64'd0);
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    issue(4'b0001, 32'h0000_00F0, 32'h0000_000F, 5'd0, 1'b1);
    chk("b2b_valid",  64'(bus.out_valid), 64'd1);
    chk("b2b_result", 64'(bus.result_o),  64'hFF);

    // Flush mid-shift, with a new op offered in the flush cycle
    repeat (2) @(negedge clk);
    issue(4'b0011, 32'd3, 32'd0, 5'd10, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    flush_i      = 1'b1;
    bus.alu_ctrl = 4'b0010;
    bus.a_i      = 32'd4;
    bus.b_i      = 32'd4;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    flush_i      = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_stall",     64'(stall_o),       64'd0);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready",  64'(bus.in_ready),  64'd1);
    repeat (12) @(posedge clk);
    #1;
    chk("flush_no_late_result", 64'(bus.out_valid), 64'd0);

    // Reset mid-shift
    issue(4'b0011, 32'd3, 32'd0, 5'd10, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_stall",     64'(stall_o),       64'd0);
    chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst_result",    64'(bus.result_o),  64'd0);
    chk("mrst_zero",      64'(bus.zero_o),    64'd1);
    chk("mrst_in_ready",  64'(bus.in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Overflow boundary and undefined code
    issue(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b1);
    issue(4'b0110, 32'h8000_0000, 32'd1, 5'd0, 1'b1);
    issue(4'b1111, 32'h1234_5678, 32'h0F0F_0F0F, 5'd0, 1'b1);

    // Randomized traffic with random output backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [3:0]   c;
      logic [W-1:0] ra, rb;
      logic [S-1:0] rs;
      c  = codes[$urandom_range(0, 7)];
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? 5'd0 : S'($urandom_range(1, 31));
      issue(c, ra, rb, rs, 1'b1);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    rand_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
